// File: rtl/bcd_down_counter_if.sv
// ============================================================================
// Module   : bcd_down_counter_if
// Purpose  : Control/status bundle between a countdown-timer client and the
//            BCD down-counter (digit 0 in the low nibble).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bcd_down_counter_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  count_en;
   logic [4*DIGITS-1:0]   q;
   logic                  zero;
   logic                  done;
   logic                  borrow;

   modport master (
      output load, load_val, count_en,
      input  q, zero, done, borrow
   );

   modport slave (
      input  load, load_val, count_en,
      output q, zero, done, borrow
   );
endinterface

`default_nettype wire

// File: rtl/bcd_down_counter.sv
// ============================================================================
// Module   : bcd_down_counter
// Purpose  : Multi-digit BCD countdown counter with clamped parallel load,
//            single-cycle borrow chain, done and wrap-borrow pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_down_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b0
) (
   input  wire logic             clk,
   input  wire logic             reset,
   bcd_down_counter_if.slave     bus
);

   localparam int c_QW = 4 * DIGITS;

   logic [c_QW-1:0]  r_q;
   logic             r_done;
   logic             r_borrow;
   logic [c_QW-1:0]  w_load;
   logic [c_QW-1:0]  w_dec;
   logic [DIGITS:0]  w_bin;
   logic             w_zero;
   logic             w_one;

   // w_bin[i] is the borrow into digit i; it ripples combinationally so the
   // whole count updates on one edge. Falling off the top means q was zero,
   // and in that case w_dec is already all-nines.
   assign w_bin[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_ld;
      assign w_d  = r_q[4*i +: 4];
      assign w_ld = bus.load_val[4*i +: 4];
      assign w_load[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
      assign w_dec[4*i +: 4]  = !w_bin[i]      ? w_d  :
                                (w_d == 4'd0)  ? 4'd9 : (w_d - 4'd1);
      assign w_bin[i+1] = w_bin[i] & (w_d == 4'd0);
   end

   assign w_zero = w_bin[DIGITS];
   assign w_one  = (r_q == {{(c_QW-4){1'b0}}, 4'd1});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q      <= '0;
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
         if (bus.load) begin
            r_q <= w_load;
         end else if (bus.count_en) begin
            if (!w_zero) begin
               r_q    <= w_dec;
               r_done <= w_one;
            end else if (WRAP) begin
               r_q      <= w_dec;
               r_borrow <= 1'b1;
            end
         end
      end
   end

   assign bus.q      = r_q;
   assign bus.zero   = w_zero;
   assign bus.done   = r_done;
   assign bus.borrow = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
// ============================================================================
// Module   : tb_bcd_down_counter
// Purpose  : Drives a hold-at-zero and a wrapping counter with identical
//            stimulus and compares both against an integer countdown model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_down_counter;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int   m_v      [2];
   bit   m_done   [2];
   bit   m_borrow [2];

   always #5 clk = ~clk;

   bcd_down_counter_if #(.DIGITS(D)) if0 ();
   bcd_down_counter_if #(.DIGITS(D)) if1 ();

   assign if1.load     = if0.load;
   assign if1.load_val = if0.load_val;
   assign if1.count_en = if0.count_en;

   bcd_down_counter #(.DIGITS(D), .WRAP(1'b0)) u_hold (.clk(clk), .reset(reset), .bus(if0.slave));
   bcd_down_counter #(.DIGITS(D), .WRAP(1'b1)) u_wrap (.clk(clk), .reset(reset), .bus(if1.slave));

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int decode_clamp(input logic [15:0] x);
      int v, p, d;
      v = 0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         d = int'(x[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * p;
         p = p * 10;
      end
      return v;
   endfunction

   function automatic logic all_bcd(input logic [15:0] x);
      for (int i = 0; i < D; i++)
         if (x[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/q0"},      if0.q,               to_bcd(m_v[0]));
      chk({tag, "/zero0"},   16'(if0.zero),       16'(m_v[0] == 0));
      chk({tag, "/done0"},   16'(if0.done),       16'(m_done[0]));
      chk({tag, "/borrow0"}, 16'(if0.borrow),     16'(m_borrow[0]));
      chk({tag, "/q1"},      if1.q,               to_bcd(m_v[1]));
      chk({tag, "/zero1"},   16'(if1.zero),       16'(m_v[1] == 0));
      chk({tag, "/done1"},   16'(if1.done),       16'(m_done[1]));
      chk({tag, "/borrow1"}, 16'(if1.borrow),     16'(m_borrow[1]));
      chk({tag, "/bcd1"},    16'(all_bcd(if1.q)), 16'd1);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_v[k] = 0; m_done[k] = 1'b0; m_borrow[k] = 1'b0;
      end
   endtask

   task automatic step(input logic ld, input logic [15:0] val, input logic en, input string tag);
      @(negedge clk);
      if0.load     = ld;
      if0.load_val = val;
      if0.count_en = en;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_done[k]   = 1'b0;
         m_borrow[k] = 1'b0;
         if (reset) begin
            m_v[k] = 0;
         end else if (ld) begin
            m_v[k] = decode_clamp(val);
         end else if (en) begin
            if (m_v[k] > 0) begin
               m_done[k] = (m_v[k] == 1);
               m_v[k]    = m_v[k] - 1;
            end else if (k == 1) begin
               m_v[k]      = 9999;
               m_borrow[k] = 1'b1;
            end
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int ndone;
      logic [15:0] rv;
      if0.load = 1'b0; if0.load_val = '0; if0.count_en = 1'b0;
      model_reset();

      // Power-on reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      @(negedge clk);
      reset = 1'b0;

      // Asynchronous reset mid-count
      step(1'b1, 16'h0427, 1'b0, "ld0427");
      chk("ld0427_const", if0.q, 16'h0427);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst_const", if0.q, 16'h0000);
      repeat (3) step(1'b0, 16'h0000, 1'b1, "rst_hold");
      @(negedge clk);
      reset = 1'b0;

      // Multi-digit borrow
      step(1'b1, 16'h1000, 1'b0, "ld1000");
      step(1'b0, 16'h0000, 1'b1, "dec1000");
      chk("dec1000_const", if0.q, 16'h0999);
      step(1'b1, 16'h0100, 1'b0, "ld0100");
      step(1'b0, 16'h0000, 1'b1, "dec0100");
      chk("dec0100_const", if0.q, 16'h0099);

      // Terminal count on both variants
      step(1'b1, 16'h0003, 1'b0, "ld0003");
      repeat (5) step(1'b0, 16'h0000, 1'b1, "term");
      step(1'b1, 16'h0001, 1'b0, "ld0001");
      step(1'b0, 16'h0000, 1'b1, "wrap_a");
      chk("wrap_a_done", 16'(if1.done), 16'd1);
      step(1'b0, 16'h0000, 1'b1, "wrap_b");
      chk("wrap_b_q", if1.q, 16'h9999);
      step(1'b0, 16'h0000, 1'b1, "wrap_c");
      chk("wrap_c_q", if1.q, 16'h9998);

      // Load beats count_en; out-of-range digits clamp
      step(1'b1, 16'h5A3F, 1'b1, "ld_clamp");
      chk("ld_clamp_const", if0.q, 16'h5939);
      step(1'b0, 16'h0000, 1'b1, "after_clamp");
      chk("after_clamp_const", if0.q, 16'h5938);
      step(1'b1, 16'h0000, 1'b1, "ld_zero");

      // Randomized mix, biased toward small values to exercise zero
      for (int n = 0; n < 400; n++) begin
         rv = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
         step(($urandom_range(0, 7) == 0), rv, $urandom_range(0, 3) != 0, "rand");
      end

      // Full sweep from 9999
      ndone = 0;
      step(1'b1, 16'h9999, 1'b0, "sweep_ld");
      for (int n = 0; n < 10000; n++) begin
         step(1'b0, 16'h0000, 1'b1, "sweep");
         if (if0.done) ndone++;
      end
      chk("sweep_done_count", 16'(ndone), 16'd1);
      chk("sweep_end_q1", if1.q, 16'h9999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
